// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared widths, client ids and request record for ram_arbiter
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;

  typedef enum logic {
    CLI_A = 1'b0,
    CLI_B = 1'b1
  } cli_e;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant generator owning the last-served pointer
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       fire,
  output logic [1:0] gnt
);

  cli_e last_q;
  cli_e last_d;

  // lone requester wins; on contention the client not served last wins
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == CLI_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // pointer only moves when an access actually fires
  always_comb begin
    last_d = last_q;
    if (fire) begin
      last_d = gnt[1] ? CLI_B : CLI_A;
    end
  end

  // reset to B so that A wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= CLI_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client round-robin front end for a single-port synchronous RAM
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0]        gnt;
  logic              a_fire;
  logic              b_fire;
  logic              fire;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] din_d;
  logic              a_pend_q;
  logic              a_pend_d;
  logic              b_pend_q;
  logic              b_pend_d;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({b_req_valid, a_req_valid}),
    .fire (fire),
    .gnt  (gnt)
  );

  // ready is the grant, held low while reset is asserted so nothing fires
  always_comb begin
    a_req_ready = gnt[0] & ~rst;
    b_req_ready = gnt[1] & ~rst;
    a_fire      = a_req_valid & a_req_ready;
    b_fire      = b_req_valid & b_req_ready;
    fire        = a_fire | b_fire;
  end

  // RAM pin mux: winner drives on a fire, otherwise an idle read of the held address
  always_comb begin
    ram_we = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    if (a_fire) begin
      ram_we = a_req_we;
      addr_d = a_req_addr;
      din_d  = a_req_wdata;
    end else if (b_fire) begin
      ram_we = b_req_we;
      addr_d = b_req_addr;
      din_d  = b_req_wdata;
    end
    ram_addr = addr_d;
    ram_din  = din_d;
  end

  // a read fire marks its owner so the registered RAM data is routed back next cycle
  always_comb begin
    a_pend_d = a_fire & ~a_req_we;
    b_pend_d = b_fire & ~b_req_we;
  end

  // address/data mirror and pending flags; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      din_q    <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      din_q    <= din_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
    end
  end

  // response routing; data is forced to zero when not addressed to the client
  always_comb begin
    a_rsp_valid = a_pend_q;
    b_rsp_valid = b_pend_q;
    a_rsp_rdata = a_pend_q ? ram_dout : '0;
    b_rsp_rdata = b_pend_q ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a sync RAM model
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req_valid, a_req_ready, a_req_we;
  logic [3:0] a_req_addr;
  logic [7:0] a_req_wdata;
  logic       a_rsp_valid;
  logic [7:0] a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_req_we;
  logic [3:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_we    (a_req_we),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_we    (b_req_we),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  // sync_ram stand-in
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
  endfunction

  // reference model: arbitration rules and memory contents at transaction level
  int         ref_last;
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic       m_ardy, m_brdy, m_we, m_arv, m_brv;
  logic [3:0] m_addr;
  logic [7:0] m_din, m_ard, m_brd;
  logic       g_ardy, g_brdy, g_we, g_arv, g_brv;
  logic [3:0] g_addr;
  logic [7:0] g_din, g_ard, g_brd;

  task automatic step(input logic av, input logic awe, input logic [3:0] aad, input logic [7:0] awd,
                      input logic bv, input logic bwe, input logic [3:0] bad, input logic [7:0] bwd);
    int win;
    a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = bad; b_req_wdata = bwd;
    #1;
    g_ardy = a_req_ready; g_brdy = b_req_ready;
    g_we = ram_we; g_addr = ram_addr; g_din = ram_din;
    if (av && bv)  win = (ref_last == 1) ? 0 : 1;
    else if (av)   win = 0;
    else if (bv)   win = 1;
    else           win = -1;
    m_ardy = (win == 0); m_brdy = (win == 1);
    m_we = 1'b0; m_arv = 1'b0; m_brv = 1'b0; m_ard = 8'h00; m_brd = 8'h00;
    if (win == 0) begin
      m_we = awe; m_addr = aad; m_din = awd; ref_last = 0;
      if (awe) ref_mem[aad] = awd;
      else begin m_arv = 1'b1; m_ard = ref_mem[aad]; end
    end else if (win == 1) begin
      m_we = bwe; m_addr = bad; m_din = bwd; ref_last = 1;
      if (bwe) ref_mem[bad] = bwd;
      else begin m_brv = 1'b1; m_brd = ref_mem[bad]; end
    end
    @(posedge clk);
    #1;
    g_arv = a_rsp_valid; g_ard = a_rsp_rdata;
    g_brv = b_rsp_valid; g_brd = b_rsp_rdata;
  endtask

  typedef struct {
    logic av, awe; logic [3:0] aad; logic [7:0] awd;
    logic bv, bwe; logic [3:0] bad; logic [7:0] bwd;
    logic ardy, brdy;
    logic arv; logic [7:0] ard;
    logic brv; logic [7:0] brd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int ra, rb;
    logic hav, hawe, hbv, hbwe;
    logic [3:0] haad, hbad;
    logic [7:0] hawd, hbwd;

    tbl[0] = '{1'b1,1'b1,4'd0,8'hAA, 1'b0,1'b0,4'd0,8'h00,  1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00};
    tbl[1] = '{1'b1,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00,  1'b1,1'b0, 1'b1,8'hAA, 1'b0,8'h00};
    tbl[2] = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,4'd15,8'h5A, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00};
    tbl[3] = '{1'b1,1'b1,4'd1,8'hBB, 1'b1,1'b0,4'd1,8'h00,  1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00};
    tbl[4] = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd1,8'h00,  1'b0,1'b1, 1'b0,8'h00, 1'b1,8'hBB};
    tbl[5] = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,4'd14,8'hC3, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00};
    tbl[6] = '{1'b1,1'b0,4'd15,8'h00,1'b1,1'b0,4'd14,8'h00, 1'b1,1'b0, 1'b1,8'h5A, 1'b0,8'h00};
    tbl[7] = '{1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd14,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b1,8'hC3};
    tbl[8] = '{1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00,  1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};

    ref_last = 1; m_addr = 4'd0; m_din = 8'h00;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 4'd3; a_req_wdata = 8'h77;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 4'd0; b_req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_b_ready", b_req_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_a_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    chk("rst_b_rsp_rdata", b_rsp_rdata, 0);
    #1;
    rst = 1'b0;

    // directed vector table: single client, contention, preload and boundary reads
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].av, tbl[i].awe, tbl[i].aad, tbl[i].awd, tbl[i].bv, tbl[i].bwe, tbl[i].bad, tbl[i].bwd);
      chk($sformatf("tbl%0d_a_ready", i), g_ardy, tbl[i].ardy);
      chk($sformatf("tbl%0d_b_ready", i), g_brdy, tbl[i].brdy);
      chk($sformatf("tbl%0d_a_rsp_valid", i), g_arv, tbl[i].arv);
      chk($sformatf("tbl%0d_a_rsp_rdata", i), g_ard, tbl[i].ard);
      chk($sformatf("tbl%0d_b_rsp_valid", i), g_brv, tbl[i].brv);
      chk($sformatf("tbl%0d_b_rsp_rdata", i), g_brd, tbl[i].brd);
    end

    // fairness: both hold reads for 8 cycles
    ra = 0; rb = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00);
      chk($sformatf("fair%0d_a_ready", i), g_ardy, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("fair%0d_b_ready", i), g_brdy, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("fair%0d_single_rsp", i), g_arv & g_brv, 0);
      chk($sformatf("fair%0d_a_data", i), g_ard, g_arv ? 32'hAA : 32'h0);
      chk($sformatf("fair%0d_b_data", i), g_brd, g_brv ? 32'hBB : 32'h0);
      ra += int'(g_arv); rb += int'(g_brv);
    end
    chk("fair_a_count", ra, 4);
    chk("fair_b_count", rb, 4);

    // idle: no valids for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      chk($sformatf("idle%0d_ram_we", i), g_we, 0);
      chk($sformatf("idle%0d_ram_addr", i), g_addr, 1);
      chk($sformatf("idle%0d_rsp", i), g_arv | g_brv, 0);
    end

    // reset with a response in flight
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    chk("mid_a_rsp_before", g_arv, 1);
    chk("mid_a_data_before", g_ard, 8'hAA);
    a_req_we = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_a_rsp_valid", a_rsp_valid, 0);
    chk("mid_rst_a_ready", a_req_ready, 0);
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    rst = 1'b0;
    ref_last = 1; m_addr = 4'd0; m_din = 8'h00;
    step(1'b1, 1'b1, 4'd2, 8'h11, 1'b1, 1'b0, 4'd2, 8'h00);
    chk("post_rst_a_ready", g_ardy, 1);
    chk("post_rst_b_ready", g_brdy, 0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
    chk("post_rst_b_rsp_valid", g_brv, 1);
    chk("post_rst_b_rsp_rdata", g_brd, 8'h11);

    // randomized traffic against the reference model, honouring the hold rule
    hav = 1'b0; hbv = 1'b0;
    hawe = 1'b0; hbwe = 1'b0; haad = 4'd0; hbad = 4'd0; hawd = 8'h00; hbwd = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (!(hav && !g_ardy)) begin
        hav = ($urandom_range(0, 3) != 0); hawe = 1'($urandom_range(0, 1));
        haad = 4'($urandom_range(0, 15)); hawd = 8'($urandom_range(0, 255));
      end
      if (!(hbv && !g_brdy)) begin
        hbv = ($urandom_range(0, 3) != 0); hbwe = 1'($urandom_range(0, 1));
        hbad = 4'($urandom_range(0, 15)); hbwd = 8'($urandom_range(0, 255));
      end
      step(hav, hawe, haad, hawd, hbv, hbwe, hbad, hbwd);
      chk($sformatf("rnd%0d_a_ready", n), g_ardy, m_ardy);
      chk($sformatf("rnd%0d_b_ready", n), g_brdy, m_brdy);
      chk($sformatf("rnd%0d_ram_we", n), g_we, m_we);
      chk($sformatf("rnd%0d_ram_addr", n), g_addr, m_addr);
      chk($sformatf("rnd%0d_ram_din", n), g_din, m_din);
      chk($sformatf("rnd%0d_a_rsp_valid", n), g_arv, m_arv);
      chk($sformatf("rnd%0d_a_rsp_rdata", n), g_ard, m_ard);
      chk($sformatf("rnd%0d_b_rsp_valid", n), g_brv, m_brv);
      chk($sformatf("rnd%0d_b_rsp_rdata", n), g_brd, m_brd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
